// File: rtl/quad_decode_debounce_if.sv
// Pin-side and strobe-side signals of the rotary-encoder front end.
// Outputs are single-cycle strobes with no ready: the consumer samples every clk.
interface quad_decode_debounce_if #(
    parameter int POS_WIDTH = 8
);
    logic                 key_A;
    logic                 key_B;
    logic                 key_S1;
    logic                 cw_pulse;
    logic                 ccw_pulse;
    logic                 btn_pulse;
    logic                 step_err;
    logic [POS_WIDTH-1:0] position;
    logic [1:0]           dbg_ab;
    logic signed [3:0]    dbg_acc;

    modport master (
        output key_A, key_B, key_S1,
        input  cw_pulse, ccw_pulse, btn_pulse, step_err, position, dbg_ab, dbg_acc
    );

    modport slave (
        input  key_A, key_B, key_S1,
        output cw_pulse, ccw_pulse, btn_pulse, step_err, position, dbg_ab, dbg_acc
    );
endinterface

// File: rtl/quad_decode_debounce.sv
// Synchronises and debounces encoder A/B and push switch, decodes quadrature
// steps into detent strobes, keeps a wrapping position and a press strobe.
module quad_decode_debounce #(
    parameter int DEBOUNCE_CYCLES  = 12000,
    parameter int STEPS_PER_DETENT = 4,
    parameter int POS_WIDTH        = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    quad_decode_debounce_if.slave  bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int ACC_W = 4;
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(STEPS_PER_DETENT);
    localparam logic signed [ACC_W-1:0] ACC_ONE = 1;

    // Bit 2 = A, bit 1 = B, bit 0 = S1; all idle high with pull-ups.
    logic [2:0]       raw;
    logic [2:0]       sync_q1;
    logic [2:0]       sync_q2;
    logic [2:0]       deb;
    logic [CNT_W-1:0] cnt [3];

    assign raw = {bus.key_A, bus.key_B, bus.key_S1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    // A differing sync value must persist DEBOUNCE_CYCLES samples to be accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb <= '1;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync_q2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sync_q2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    logic [1:0]              ab;
    logic [1:0]              ab_prev;
    logic                    s1_prev;
    logic                    step_cw;
    logic                    step_ccw;
    logic                    step_bad;
    logic                    cw_next;
    logic                    ccw_next;
    logic                    btn_next;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_step;

    assign ab = deb[2:1];

    always_comb begin
        step_cw  = 1'b0;
        step_ccw = 1'b0;
        case ({ab_prev, ab})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_cw  = 1'b1;
            4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: step_ccw = 1'b1;
            default: ;
        endcase
        step_bad = ((ab_prev ^ ab) == 2'b11);
        acc_step = acc;
        if (step_cw)       acc_step = acc + ACC_ONE;
        else if (step_ccw) acc_step = acc - ACC_ONE;
        cw_next  = !step_bad && (acc_step == ACC_MAX);
        ccw_next = !step_bad && (acc_step == -ACC_MAX);
        btn_next = s1_prev && !deb[0];
    end

    logic                 cw_q;
    logic                 ccw_q;
    logic                 btn_q;
    logic                 err_q;
    logic [POS_WIDTH-1:0] pos_q;

    // A press clears position even when a detent lands on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ab_prev <= 2'b11;
            s1_prev <= 1'b1;
            acc     <= '0;
            cw_q    <= 1'b0;
            ccw_q   <= 1'b0;
            btn_q   <= 1'b0;
            err_q   <= 1'b0;
            pos_q   <= '0;
        end else begin
            ab_prev <= ab;
            s1_prev <= deb[0];
            cw_q    <= cw_next;
            ccw_q   <= ccw_next;
            btn_q   <= btn_next;
            err_q   <= step_bad;
            if (step_bad || cw_next || ccw_next) acc <= '0;
            else                                 acc <= acc_step;
            if (btn_next)      pos_q <= '0;
            else if (cw_next)  pos_q <= pos_q + 1'b1;
            else if (ccw_next) pos_q <= pos_q - 1'b1;
        end
    end

    assign bus.cw_pulse  = cw_q;
    assign bus.ccw_pulse = ccw_q;
    assign bus.btn_pulse = btn_q;
    assign bus.step_err  = err_q;
    assign bus.position  = pos_q;
    assign bus.dbg_ab    = ab;
    assign bus.dbg_acc   = acc;
endmodule

// File: tb/tb_quad_decode_debounce.sv
// Directed bench for quad_decode_debounce with DEBOUNCE_CYCLES=4, STEPS_PER_DETENT=4.
module tb_quad_decode_debounce;
    localparam int DEB = 4;
    localparam int SPD = 4;
    localparam int PW  = 8;
    localparam int LAT = DEB + 3;

    logic clk = 1'b0;
    logic rst;

    quad_decode_debounce_if #(.POS_WIDTH(PW)) bus ();

    quad_decode_debounce #(
        .DEBOUNCE_CYCLES (DEB),
        .STEPS_PER_DETENT(SPD),
        .POS_WIDTH       (PW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int edge_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    int cw_cnt = 0, ccw_cnt = 0, err_cnt = 0, btn_cnt = 0, ab_chg = 0;
    int last_cw_cyc = 0, last_ccw_cyc = 0, last_btn_cyc = 0;
    logic [1:0] ab_seen = 2'b11;

    always @(negedge clk) begin
        if (bus.cw_pulse === 1'b1)  begin cw_cnt++;  last_cw_cyc  = cyc; end
        if (bus.ccw_pulse === 1'b1) begin ccw_cnt++; last_ccw_cyc = cyc; end
        if (bus.btn_pulse === 1'b1) begin btn_cnt++; last_btn_cyc = cyc; end
        if (bus.step_err === 1'b1)  err_cnt++;
        if (bus.dbg_ab !== ab_seen) ab_chg++;
        ab_seen = bus.dbg_ab;
    end

    task automatic set_ab(input logic a, input logic b, input int hold);
        @(negedge clk);
        bus.key_A = a;
        bus.key_B = b;
        edge_cyc  = cyc;
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic cw_cycle_from_11();
        set_ab(1'b0, 1'b1, 20);
        set_ab(1'b0, 1'b0, 20);
        set_ab(1'b1, 1'b0, 20);
        set_ab(1'b1, 1'b1, 20);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.key_A = 1'b1; bus.key_B = 1'b1; bus.key_S1 = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.cw_pulse, bus.ccw_pulse, bus.btn_pulse, bus.step_err} !== 4'b0000) begin
            bad++; $display("FAIL reset_pulses: got %b want 0000",
                            {bus.cw_pulse, bus.ccw_pulse, bus.btn_pulse, bus.step_err});
        end
        total++;
        if (bus.position !== 8'd0) begin
            bad++; $display("FAIL reset_position: got %0d want 0", bus.position);
        end
        total++;
        if (bus.dbg_ab !== 2'b11) begin
            bad++; $display("FAIL reset_ab: got %b want 11", bus.dbg_ab);
        end
        total++;
        if (bus.dbg_acc !== 4'sd0) begin
            bad++; $display("FAIL reset_acc: got %0d want 0", bus.dbg_acc);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_ccw();
        int c_cw = cw_cnt, c_ccw = ccw_cnt, c_err = err_cnt;
        set_ab(1'b1, 1'b0, 20);
        set_ab(1'b0, 1'b0, 20);
        set_ab(1'b0, 1'b1, 20);
        set_ab(1'b1, 1'b1, 20);
        total++;
        if (ccw_cnt - c_ccw != 1 || cw_cnt - c_cw != 0) begin
            bad++; $display("FAIL ccw_count: got ccw=%0d cw=%0d want ccw=1 cw=0",
                            ccw_cnt - c_ccw, cw_cnt - c_cw);
        end
        total++;
        if (last_ccw_cyc - edge_cyc != LAT) begin
            bad++; $display("FAIL ccw_latency: got %0d want %0d", last_ccw_cyc - edge_cyc, LAT);
        end
        total++;
        if (bus.position !== 8'd255) begin
            bad++; $display("FAIL ccw_wrap_position: got %0d want 255", bus.position);
        end
        total++;
        if (err_cnt != c_err) begin
            bad++; $display("FAIL ccw_step_err: got %0d want 0", err_cnt - c_err);
        end
    endtask

    task automatic test_cw();
        int c_cw = cw_cnt, c_ccw = ccw_cnt, c_err = err_cnt;
        cw_cycle_from_11();
        total++;
        if (cw_cnt - c_cw != 1 || ccw_cnt != c_ccw) begin
            bad++; $display("FAIL cw_count: got cw=%0d ccw=%0d want cw=1 ccw=0",
                            cw_cnt - c_cw, ccw_cnt - c_ccw);
        end
        total++;
        if (last_cw_cyc - edge_cyc != LAT) begin
            bad++; $display("FAIL cw_latency: got %0d want %0d", last_cw_cyc - edge_cyc, LAT);
        end
        total++;
        if (bus.position !== 8'd0) begin
            bad++; $display("FAIL cw_wrap_position: got %0d want 0", bus.position);
        end
        cw_cycle_from_11();
        total++;
        if (bus.position !== 8'd1 || cw_cnt - c_cw != 2) begin
            bad++; $display("FAIL cw_second_detent: got pos=%0d cw=%0d want pos=1 cw=2",
                            bus.position, cw_cnt - c_cw);
        end
        total++;
        if (err_cnt != c_err) begin
            bad++; $display("FAIL cw_step_err: got %0d want 0", err_cnt - c_err);
        end
    endtask

    task automatic test_glitch();
        int c_ev = cw_cnt + ccw_cnt + err_cnt;
        int c_ab = ab_chg;
        @(negedge clk); bus.key_A = 1'b0;
        repeat (3) @(negedge clk); bus.key_A = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if (ab_chg != c_ab || bus.dbg_acc !== 4'sd0) begin
            bad++; $display("FAIL glitch3_ignored: got ab_changes=%0d acc=%0d want 0 0",
                            ab_chg - c_ab, bus.dbg_acc);
        end
        @(negedge clk); bus.key_A = 1'b0;
        repeat (4) @(negedge clk); bus.key_A = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (bus.dbg_ab !== 2'b01 || bus.dbg_acc !== 4'sd1) begin
            bad++; $display("FAIL glitch4_accepted: got ab=%b acc=%0d want ab=01 acc=1",
                            bus.dbg_ab, bus.dbg_acc);
        end
        repeat (20) @(negedge clk);
        total++;
        if (cw_cnt + ccw_cnt + err_cnt != c_ev || bus.dbg_acc !== 4'sd0) begin
            bad++; $display("FAIL glitch_no_pulse: got events=%0d acc=%0d want 0 0",
                            cw_cnt + ccw_cnt + err_cnt - c_ev, bus.dbg_acc);
        end
    endtask

    task automatic test_illegal();
        int c_cw = cw_cnt, c_ccw = ccw_cnt, c_err = err_cnt;
        set_ab(1'b0, 1'b0, 20);
        total++;
        if (err_cnt - c_err != 1 || bus.dbg_acc !== 4'sd0 || cw_cnt != c_cw) begin
            bad++; $display("FAIL illegal_jump: got err=%0d acc=%0d cw=%0d want 1 0 0",
                            err_cnt - c_err, bus.dbg_acc, cw_cnt - c_cw);
        end
        set_ab(1'b1, 1'b0, 20);
        set_ab(1'b1, 1'b1, 20);
        set_ab(1'b0, 1'b1, 20);
        set_ab(1'b0, 1'b0, 20);
        total++;
        if (cw_cnt - c_cw != 1 || bus.position !== 8'd2) begin
            bad++; $display("FAIL illegal_recover: got cw=%0d pos=%0d want 1 2",
                            cw_cnt - c_cw, bus.position);
        end
        set_ab(1'b1, 1'b0, 20);
        set_ab(1'b1, 1'b1, 20);
        total++;
        if (bus.dbg_acc !== 4'sd2) begin
            bad++; $display("FAIL illegal_acc_build: got %0d want 2", bus.dbg_acc);
        end
        set_ab(1'b0, 1'b0, 20);
        total++;
        if (bus.dbg_acc !== 4'sd0 || err_cnt - c_err != 2) begin
            bad++; $display("FAIL illegal_acc_clear: got acc=%0d err=%0d want 0 2",
                            bus.dbg_acc, err_cnt - c_err);
        end
        set_ab(1'b1, 1'b1, 20);
        total++;
        if (err_cnt - c_err != 3 || cw_cnt - c_cw != 1 || ccw_cnt != c_ccw) begin
            bad++; $display("FAIL illegal_back: got err=%0d cw=%0d ccw=%0d want 3 1 0",
                            err_cnt - c_err, cw_cnt - c_cw, ccw_cnt - c_ccw);
        end
    endtask

    task automatic test_button();
        int c_btn;
        int press_cyc;
        cw_cycle_from_11();
        total++;
        if (bus.position !== 8'd3) begin
            bad++; $display("FAIL button_pre_position: got %0d want 3", bus.position);
        end
        c_btn = btn_cnt;
        @(negedge clk); bus.key_S1 = 1'b0; press_cyc = cyc;
        repeat (49) @(negedge clk);
        total++;
        if (btn_cnt - c_btn != 1 || bus.position !== 8'd0) begin
            bad++; $display("FAIL button_press: got btn=%0d pos=%0d want 1 0",
                            btn_cnt - c_btn, bus.position);
        end
        total++;
        if (last_btn_cyc - press_cyc != LAT) begin
            bad++; $display("FAIL button_latency: got %0d want %0d", last_btn_cyc - press_cyc, LAT);
        end
        @(negedge clk); bus.key_S1 = 1'b1;
        repeat (30) @(negedge clk);
        total++;
        if (btn_cnt - c_btn != 1) begin
            bad++; $display("FAIL button_release: got btn=%0d want 1", btn_cnt - c_btn);
        end
    endtask

    task automatic test_back_to_back();
        int c_cw = cw_cnt, c_btn = btn_cnt;
        set_ab(1'b0, 1'b1, 20);
        set_ab(1'b0, 1'b0, 20);
        set_ab(1'b1, 1'b0, 20);
        @(negedge clk);
        bus.key_A = 1'b1; bus.key_B = 1'b1; bus.key_S1 = 1'b0;
        repeat (19) @(negedge clk);
        total++;
        if (cw_cnt - c_cw != 1 || btn_cnt - c_btn != 1) begin
            bad++; $display("FAIL same_cycle_pulses: got cw=%0d btn=%0d want 1 1",
                            cw_cnt - c_cw, btn_cnt - c_btn);
        end
        total++;
        if (last_cw_cyc != last_btn_cyc) begin
            bad++; $display("FAIL same_cycle_align: got cw@%0d btn@%0d want equal",
                            last_cw_cyc, last_btn_cyc);
        end
        total++;
        if (bus.position !== 8'd0) begin
            bad++; $display("FAIL same_cycle_clear_wins: got %0d want 0", bus.position);
        end
        @(negedge clk); bus.key_S1 = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int c_cw, c_err;
        cw_cycle_from_11();
        total++;
        if (bus.position !== 8'd1) begin
            bad++; $display("FAIL rstmid_pre_position: got %0d want 1", bus.position);
        end
        set_ab(1'b0, 1'b1, 20);
        set_ab(1'b0, 1'b0, 20);
        total++;
        if (bus.dbg_acc !== 4'sd2) begin
            bad++; $display("FAIL rstmid_pre_acc: got %0d want 2", bus.dbg_acc);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.position !== 8'd0 || bus.dbg_acc !== 4'sd0 || bus.cw_pulse !== 1'b0) begin
            bad++; $display("FAIL rstmid_async: got pos=%0d acc=%0d cw=%b want 0 0 0",
                            bus.position, bus.dbg_acc, bus.cw_pulse);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        c_cw = cw_cnt; c_err = err_cnt;
        repeat (20) @(negedge clk);
        total++;
        if (err_cnt - c_err != 1 || bus.dbg_acc !== 4'sd0 || bus.dbg_ab !== 2'b00) begin
            bad++; $display("FAIL rstmid_reacquire: got err=%0d acc=%0d ab=%b want 1 0 00",
                            err_cnt - c_err, bus.dbg_acc, bus.dbg_ab);
        end
        set_ab(1'b1, 1'b0, 20);
        set_ab(1'b1, 1'b1, 20);
        total++;
        if (cw_cnt != c_cw || bus.dbg_acc !== 4'sd2) begin
            bad++; $display("FAIL rstmid_partial: got cw=%0d acc=%0d want 0 2",
                            cw_cnt - c_cw, bus.dbg_acc);
        end
        cw_cycle_from_11();
        total++;
        if (cw_cnt - c_cw != 1 || bus.position !== 8'd1) begin
            bad++; $display("FAIL rstmid_next_cycle: got cw=%0d pos=%0d want 1 1",
                            cw_cnt - c_cw, bus.position);
        end
    endtask

    initial begin
        test_reset();
        test_ccw();
        test_cw();
        test_glitch();
        test_illegal();
        test_button();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
